// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback, with a bounded wait on memory and a sticky trap state.
//
// Memory handshake: while in FETCH, MEM_READ or MEM_WRITE the request strobe
// (mem_read / mem_write) is held high every cycle; the access completes on the
// cycle mem_ready=1 is seen, and the FSM advances on that edge. If mem_ready
// stays low for MAX_WAIT extra cycles the core traps instead.
module multicycle_control #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_o
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_R    = 4'b0111;
    localparam logic [3:0] ALU_ORI  = 4'b0101;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_ANDI = 4'b0011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     cause_q, cause_d;
    logic           timed_out;

    // Wait expiry: only meaningful in a memory state with mem_ready low.
    assign timed_out = (MAX_WAIT != 0) && (cnt_q == CW'(MAX_WAIT));

    // State, wait counter and trap cause registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state, wait-count and trap-cause selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cause_d = cause_q;
        case (state_q)
            S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
                if (mem_ready) begin
                    case (state_q)
                        S_FETCH:    state_d = S_DECODE;
                        S_MEM_READ: state_d = S_MEM_WB;
                        default:    state_d = S_FETCH;
                    endcase
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_R:                             state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls; reset suppresses every write/request strobe.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 2'b00;
        reg_dst    = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 4'b0000;
        pc_source  = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_R;
            end
            S_R_WB: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op)
                    OP_ANDI: alu_op = ALU_ANDI;
                    OP_ORI:  alu_op = ALU_ORI;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                pc_write  = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            S_JAL: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
            end
            S_JR: begin
                pc_source = 2'b11;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each stimulus cycle pushes its
// hand-written expected output vector; a negedge monitor pops and compares.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic [1:0] mem_to_reg, reg_dst, alu_src_b, pc_source, trap_cause;
    logic       reg_write, alu_src_a, trap;
    logic [3:0] alu_op, state_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [25:0] exp_q[$];
    string       name_q[$];

    multicycle_control #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .trap(trap), .trap_cause(trap_cause),
        .state_o(state_o)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Expected vector layout:
    // {state, pcw, irw, iod, mr, mw, m2r, rdst, rw, asa, asb, aop, pcs, trap, cause}
    function automatic logic [25:0] mk(
        input logic [3:0] st, input logic pcw, input logic irw, input logic iod,
        input logic mr, input logic mw, input logic [1:0] m2r, input logic [1:0] rdst,
        input logic rw, input logic asa, input logic [1:0] asb, input logic [3:0] aop,
        input logic [1:0] pcs, input logic tr, input logic [1:0] tc);
        return {st, pcw, irw, iod, mr, mw, m2r, rdst, rw, asa, asb, aop, pcs, tr, tc};
    endfunction

    logic [25:0] v_f_rst, v_f_wait, v_f_rdy, v_dec, v_rex, v_rwb, v_ma, v_mr, v_mwb;
    logic [25:0] v_mw, v_mw_rst, v_ie_ori, v_ie_andi, v_ie_lui, v_ie_addi, v_iwb;
    logic [25:0] v_br_t, v_br_n, v_jmp, v_jal, v_jr, v_tr_ill, v_tr_to;

    initial begin
        //            st     pcw  irw  iod  mr   mw   m2r    rdst   rw   asa  asb    aop      pcs    tr   tc
        v_f_rst   = mk(4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,4'b0100,2'b00,1'b0,2'b00);
        v_f_wait  = mk(4'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,4'b0100,2'b00,1'b0,2'b00);
        v_f_rdy   = mk(4'd0, 1'b1,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,4'b0100,2'b00,1'b0,2'b00);
        v_dec     = mk(4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,4'b0100,2'b00,1'b0,2'b00);
        v_ma      = mk(4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,4'b0100,2'b00,1'b0,2'b00);
        v_mr      = mk(4'd3, 1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,4'b0000,2'b00,1'b0,2'b00);
        v_mwb     = mk(4'd4, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,1'b0,2'b00,4'b0000,2'b00,1'b0,2'b00);
        v_mw      = mk(4'd5, 1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b00,4'b0000,2'b00,1'b0,2'b00);
        v_mw_rst  = mk(4'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,4'b0000,2'b00,1'b0,2'b00);
        v_rex     = mk(4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,4'b0111,2'b00,1'b0,2'b00);
        v_rwb     = mk(4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,1'b0,2'b00,4'b0000,2'b00,1'b0,2'b00);
        v_ie_ori  = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,4'b0101,2'b00,1'b0,2'b00);
        v_ie_andi = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,4'b0011,2'b00,1'b0,2'b00);
        v_ie_lui  = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,4'b0110,2'b00,1'b0,2'b00);
        v_ie_addi = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,4'b0100,2'b00,1'b0,2'b00);
        v_iwb     = mk(4'd9, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,2'b00,4'b0000,2'b00,1'b0,2'b00);
        v_br_t    = mk(4'd10,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,4'b0001,2'b01,1'b0,2'b00);
        v_br_n    = mk(4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,4'b0001,2'b01,1'b0,2'b00);
        v_jmp     = mk(4'd11,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,4'b0000,2'b10,1'b0,2'b00);
        v_jal     = mk(4'd12,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,1'b1,1'b0,2'b00,4'b0000,2'b10,1'b0,2'b00);
        v_jr      = mk(4'd13,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,4'b0000,2'b11,1'b0,2'b00);
        v_tr_ill  = mk(4'd14,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,4'b0000,2'b00,1'b1,2'b01);
        v_tr_to   = mk(4'd14,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,4'b0000,2'b00,1'b1,2'b10);
    end

    // Driver: apply one cycle of inputs and queue what that cycle must show.
    task automatic step(input string nm, input logic rst, input logic rdy, input logic z,
                        input logic [5:0] o, input logic [5:0] f, input logic [25:0] e);
        reset     = rst;
        mem_ready = rdy;
        zero      = z;
        op        = o;
        funct     = f;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [25:0] act;
            logic [25:0] e;
            string nm;
            act = {state_o, pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, trap, trap_cause};
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step("reset_state", 1, 1, 0, 6'h00, 6'h00, v_f_rst);

        // ADD: 0,1,6,7
        step("add_fetch",  0, 1, 0, 6'h00, 6'h20, v_f_rdy);
        step("add_decode", 0, 1, 0, 6'h00, 6'h20, v_dec);
        step("add_exec",   0, 1, 0, 6'h00, 6'h20, v_rex);
        step("add_wb",     0, 1, 0, 6'h00, 6'h20, v_rwb);

        // LW with three wait cycles in MEM_READ
        step("lw_fetch",  0, 1, 0, 6'h23, 6'h00, v_f_rdy);
        step("lw_decode", 0, 1, 0, 6'h23, 6'h00, v_dec);
        step("lw_addr",   0, 1, 0, 6'h23, 6'h00, v_ma);
        for (int i = 0; i < 3; i++)
            step("lw_read_wait", 0, 0, 0, 6'h23, 6'h00, v_mr);
        step("lw_read_done", 0, 1, 0, 6'h23, 6'h00, v_mr);
        step("lw_wb",        0, 1, 0, 6'h23, 6'h00, v_mwb);

        // SW, ready on entry
        step("sw_fetch",  0, 1, 0, 6'h2B, 6'h00, v_f_rdy);
        step("sw_decode", 0, 1, 0, 6'h2B, 6'h00, v_dec);
        step("sw_addr",   0, 1, 0, 6'h2B, 6'h00, v_ma);
        step("sw_write",  0, 1, 0, 6'h2B, 6'h00, v_mw);

        // I-type ALU ops
        step("ori_fetch",  0, 1, 0, 6'h0D, 6'h00, v_f_rdy);
        step("ori_decode", 0, 1, 0, 6'h0D, 6'h00, v_dec);
        step("ori_exec",   0, 1, 0, 6'h0D, 6'h00, v_ie_ori);
        step("ori_wb",     0, 1, 0, 6'h0D, 6'h00, v_iwb);
        step("andi_fetch",  0, 1, 0, 6'h0C, 6'h00, v_f_rdy);
        step("andi_decode", 0, 1, 0, 6'h0C, 6'h00, v_dec);
        step("andi_exec",   0, 1, 0, 6'h0C, 6'h00, v_ie_andi);
        step("andi_wb",     0, 1, 0, 6'h0C, 6'h00, v_iwb);
        step("lui_fetch",  0, 1, 0, 6'h0F, 6'h00, v_f_rdy);
        step("lui_decode", 0, 1, 0, 6'h0F, 6'h00, v_dec);
        step("lui_exec",   0, 1, 0, 6'h0F, 6'h00, v_ie_lui);
        step("lui_wb",     0, 1, 0, 6'h0F, 6'h00, v_iwb);
        step("addi_fetch",  0, 1, 0, 6'h08, 6'h00, v_f_rdy);
        step("addi_decode", 0, 1, 0, 6'h08, 6'h00, v_dec);
        step("addi_exec",   0, 1, 0, 6'h08, 6'h00, v_ie_addi);
        step("addi_wb",     0, 1, 0, 6'h08, 6'h00, v_iwb);

        // Branches: taken/not taken for BEQ and BNE
        step("beq1_fetch",  0, 1, 1, 6'h04, 6'h00, v_f_rdy);
        step("beq1_decode", 0, 1, 1, 6'h04, 6'h00, v_dec);
        step("beq1_branch", 0, 1, 1, 6'h04, 6'h00, v_br_t);
        step("beq0_fetch",  0, 1, 0, 6'h04, 6'h00, v_f_rdy);
        step("beq0_decode", 0, 1, 0, 6'h04, 6'h00, v_dec);
        step("beq0_branch", 0, 1, 0, 6'h04, 6'h00, v_br_n);
        step("bne1_fetch",  0, 1, 1, 6'h05, 6'h00, v_f_rdy);
        step("bne1_decode", 0, 1, 1, 6'h05, 6'h00, v_dec);
        step("bne1_branch", 0, 1, 1, 6'h05, 6'h00, v_br_n);
        step("bne0_fetch",  0, 1, 0, 6'h05, 6'h00, v_f_rdy);
        step("bne0_decode", 0, 1, 0, 6'h05, 6'h00, v_dec);
        step("bne0_branch", 0, 1, 0, 6'h05, 6'h00, v_br_t);

        // Jumps
        step("j_fetch",    0, 1, 0, 6'h02, 6'h00, v_f_rdy);
        step("j_decode",   0, 1, 0, 6'h02, 6'h00, v_dec);
        step("j_jump",     0, 1, 0, 6'h02, 6'h00, v_jmp);
        step("jal_fetch",  0, 1, 0, 6'h03, 6'h00, v_f_rdy);
        step("jal_decode", 0, 1, 0, 6'h03, 6'h00, v_dec);
        step("jal_jal",    0, 1, 0, 6'h03, 6'h00, v_jal);
        step("jr_fetch",   0, 1, 0, 6'h00, 6'h08, v_f_rdy);
        step("jr_decode",  0, 1, 0, 6'h00, 6'h08, v_dec);
        step("jr_jr",      0, 1, 0, 6'h00, 6'h08, v_jr);

        // Fetch ready on the last allowed wait cycle (cnt==15) is accepted
        for (int i = 0; i < 15; i++)
            step("fetch_wait_edge", 0, 0, 0, 6'h00, 6'h20, v_f_wait);
        step("fetch_ready_at_limit", 0, 1, 0, 6'h00, 6'h20, v_f_rdy);
        step("limit_decode",         0, 1, 0, 6'h00, 6'h20, v_dec);
        step("limit_exec",           0, 1, 0, 6'h00, 6'h20, v_rex);
        step("limit_wb",             0, 1, 0, 6'h00, 6'h20, v_rwb);

        // Illegal opcode traps and holds until reset
        step("ill_fetch",  0, 1, 0, 6'h3F, 6'h00, v_f_rdy);
        step("ill_decode", 0, 1, 0, 6'h3F, 6'h00, v_dec);
        for (int i = 0; i < 20; i++)
            step("ill_trap_hold", 0, 1, 0, 6'h3F, 6'h00, v_tr_ill);
        step("ill_reset_cycle", 1, 1, 0, 6'h00, 6'h20, v_tr_ill);
        step("after_ill_reset", 0, 1, 0, 6'h00, 6'h20, v_f_rdy);
        step("after_ill_dec",   0, 1, 0, 6'h00, 6'h20, v_dec);
        step("after_ill_exec",  0, 1, 0, 6'h00, 6'h20, v_rex);
        step("after_ill_wb",    0, 1, 0, 6'h00, 6'h20, v_rwb);

        // Fetch timeout: 16 waiting cycles then TRAP cause 10
        for (int i = 0; i < 16; i++)
            step("to_fetch_wait", 0, 0, 0, 6'h00, 6'h20, v_f_wait);
        for (int i = 0; i < 3; i++)
            step("to_trap_hold", 0, 1, 0, 6'h00, 6'h20, v_tr_to);
        step("to_reset_cycle", 1, 0, 0, 6'h2B, 6'h00, v_tr_to);

        // Reset during MEM_WRITE aborts the write
        step("swr_fetch",  0, 1, 0, 6'h2B, 6'h00, v_f_rdy);
        step("swr_decode", 0, 1, 0, 6'h2B, 6'h00, v_dec);
        step("swr_addr",   0, 1, 0, 6'h2B, 6'h00, v_ma);
        step("swr_wait",   0, 0, 0, 6'h2B, 6'h00, v_mw);
        step("swr_reset",  1, 0, 0, 6'h2B, 6'h00, v_mw_rst);
        step("swr_after",  0, 1, 0, 6'h2B, 6'h00, v_f_rdy);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore/Mealy FSM that sequences the multi-cycle MIPS datapath through fetch, decode, execute, memory and writeback. It drives the shared-memory, IR, PC, ALU-mux and register-file controls for each instruction step by step, replacing the single-cycle opcode decoder. Memory accesses use a ready handshake with timeout. Illegal opcodes and memory timeouts stop the core in a trap state.

Parameters:
MAX_WAIT, 15, number of extra cycles a memory access may wait for mem_ready before trapping; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  6  opcode field, IR[31:26]
funct  input  6  function field, IR[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current read/write this cycle
pc_write  output  1  PC register load enable
ir_write  output  1  instruction register load enable
i_or_d  output  1  memory address mux: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_to_reg  output  2  writeback source: 00=ALUOut, 01=MDR, 10=PC
reg_dst  output  2  destination register: 00=rt, 01=rd, 10=$31
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A input: 0=PC, 1=rs
alu_src_b  output  2  ALU B input: 00=rt, 01=4, 10=signext imm, 11=signext imm<<2
alu_op  output  4  ADD=0100, SUB=0001, R-type=0111, ORI=0101, LUI=0110, ANDI=0011
pc_source  output  2  next PC: 00=ALU, 01=ALUOut, 10=jump target, 11=rs (jr)
trap  output  1  core halted
trap_cause  output  2  00=none, 01=illegal opcode, 10=memory timeout
state_o  output  4  current state encoding, for debug

Behaviour:
- Reset: on a clk edge with reset=1, state becomes FETCH, wait counter is cleared and trap/trap_cause are cleared. While reset=1, pc_write, ir_write, mem_read, mem_write and reg_write are forced to 0. A reset asserted mid-access aborts that access.
- Unlisted outputs in each state are 0.
- Opcode map: R=00 (jr is funct 08), ADDI=08, ANDI=0C, ORI=0D, LUI=0F, BEQ=04, BNE=05, LW=23, SW=2B, J=02, JAL=03.
- States and state_o encodings:
  - FETCH(0): mem_read=1, alu_src_b=01, alu_op=ADD. When mem_ready=1: ir_write=1 and pc_write=1 (Mealy, same cycle), then go to DECODE.
  - DECODE(1): alu_src_b=11, alu_op=ADD, precomputing the branch target into ALUOut. Dispatch:
    - LW/SW -> MEM_ADDR
    - R with funct!=08 -> R_EXEC; R with funct=08 -> JR
    - ADDI/ANDI/ORI/LUI -> I_EXEC
    - BEQ/BNE -> BRANCH
    - J -> JUMP; JAL -> JAL
    - any other opcode -> TRAP with cause 01
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=ADD. Next: LW -> MEM_READ, SW -> MEM_WRITE.
  - MEM_READ(3): i_or_d=1, mem_read=1. When mem_ready=1 -> MEM_WB.
  - MEM_WB(4): reg_dst=00, mem_to_reg=01, reg_write=1, then FETCH.
  - MEM_WRITE(5): i_or_d=1, mem_write=1. When mem_ready=1 -> FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=0111, then R_WB.
  - R_WB(7): reg_dst=01, reg_write=1, then FETCH.
  - I_EXEC(8): alu_src_a=1, alu_src_b=10, alu_op per opcode (ADDI uses ADD), then I_WB.
  - I_WB(9): reg_dst=00, reg_write=1, then FETCH.
  - BRANCH(10): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01. pc_write=(BEQ&zero)|(BNE&~zero), Mealy. Then FETCH.
  - JUMP(11): pc_source=10, pc_write=1, then FETCH.
  - JAL(12): pc_source=10, pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1, then FETCH. $31 captures the pre-edge PC, i.e. PC+4.
  - JR(13): pc_source=11, pc_write=1, then FETCH.
  - TRAP(14): all strobes 0, trap=1, trap_cause held. Left only by reset.
- Latencies with mem_ready high on entry: R/I-type 4 cycles, LW 5, SW 4, branch/J/JAL/JR 3.
- Wait counter (applies in FETCH, MEM_READ and MEM_WRITE):
  - Counter is 0 on the entry cycle of each memory state.
  - mem_ready=1 advances the FSM.
  - mem_ready=0 with cnt==MAX_WAIT (MAX_WAIT>0) goes to TRAP with cause 10.
  - Otherwise cnt increments.
  - mem_ready=1 on the cycle cnt==MAX_WAIT is accepted; ready wins.
- op and funct are sampled only in DECODE, MEM_ADDR, I_EXEC and BRANCH. The IR is stable from DECODE onward.

Test Plan:
- ADD (op=00, funct=20), mem_ready tied 1 -> states 0,1,6,7,0; reg_write=1 with reg_dst=01 in cycle 4 only; pc_write=1 only in cycle 1.
- LW (op=23), mem_ready low for 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; mem_read and i_or_d=1 held through the waits; mem_to_reg=01 in MEM_WB.
- BEQ with zero=1 -> pc_write=1 and pc_source=01 in BRANCH; BNE with zero=1 -> pc_write=0; BNE with zero=0 -> pc_write=1.
- JAL (op=03) -> in state 12: reg_dst=10, mem_to_reg=10, reg_write=1, pc_write=1, pc_source=10.
- Illegal op=3F -> TRAP after DECODE, trap=1, cause=01, stays there for 20 cycles; reset=1 for one cycle -> FETCH, trap=0.
- MAX_WAIT=15, mem_ready never asserted in FETCH -> TRAP with cause 10 on the edge after 16 FETCH cycles. Separately, reset asserted in MEM_WRITE -> mem_write=0 in the same cycle, FETCH next.
